// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  // Request as captured in IDLE; the access uses only this copy.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
    logic            rw;
  } dmem_req_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the memory stage (master) and the responder (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
();
  logic            i_mem_req;
  logic [XLEN-1:0] i_mem_addr;
  logic [XLEN-1:0] i_mem_data;
  logic [2:0]      i_funct3;
  logic            i_read_write;
  logic            or_mem_ack;
  logic [XLEN-1:0] or_mem_data;
  logic            or_mem_err;
  logic            or_busy;

  modport master (
    output i_mem_req, i_mem_addr, i_mem_data, i_funct3, i_read_write,
    input  or_mem_ack, or_mem_data, or_mem_err, or_busy
  );

  modport slave (
    input  i_mem_req, i_mem_addr, i_mem_data, i_funct3, i_read_write,
    output or_mem_ack, or_mem_data, or_mem_err, or_busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store merge into the old word, load extract/extend, misalign detect.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] new_word,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);
  logic [XLEN-1:0] shifted;

  // Merge store data into the addressed bytes; untouched bytes keep the old value.
  always_comb begin
    new_word = old_word;
    case (funct3[1:0])
      2'b00:   new_word[{lane, 3'b000} +: 8]   = wdata[7:0];
      2'b01:   new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10:   new_word = wdata;
      default: new_word = old_word;
    endcase
  end

  // Right-justify the addressed lane, then sign- or zero-extend by funct3.
  always_comb begin
    shifted   = old_word >> {lane, 3'b000};
    load_data = old_word;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = old_word;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment.
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = (lane != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, waits LATENCY cycles, performs the
// access on a word RAM and returns a one-cycle ack with load data or an error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int              DEPTH     = 1024,
  parameter int              LATENCY   = 1,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input logic             i_clk,
  input logic             i_rst_n,
  dmem_responder_if.slave bus
);
  localparam int              AW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  dmem_req_t       req_q, req_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [XLEN-1:0] ram [DEPTH];
  logic [XLEN-1:0] offset;
  logic [AW-1:0]   idx;
  logic            in_range, bad_f3, misalign, acc_err, wr_en;
  logic [XLEN-1:0] old_word, new_word, load_data;

  // Decode the captured request: word index, range and legality.
  always_comb begin
    offset   = req_q.addr - BASE_ADDR;
    in_range = (req_q.addr >= BASE_ADDR) && (offset < SPAN);
    idx      = offset[AW+1:2];
    old_word = ram[idx];
    bad_f3   = (req_q.funct3 == 3'b011) || (req_q.funct3[2:1] == 2'b11) ||
               (req_q.rw && req_q.funct3[2]);
    acc_err  = bad_f3 || misalign || !in_range;
  end

  dmem_lane_align u_align (
    .old_word  (old_word),
    .wdata     (req_q.data),
    .lane      (req_q.addr[1:0]),
    .funct3    (req_q.funct3),
    .new_word  (new_word),
    .load_data (load_data),
    .misalign  (misalign)
  );

  // Next-state and output logic; ack/err default low so they pulse for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    wr_en   = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (bus.i_mem_req) begin
          req_d   = '{addr: bus.i_mem_addr, data: bus.i_mem_data,
                      funct3: bus.i_funct3, rw: bus.i_read_write};
          cnt_d   = 4'(LATENCY);
          state_d = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = DMEM_DONE;
          if (acc_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_q.rw) begin
            wr_en   = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = load_data;
          end
        end
      end
      DMEM_DONE: begin
        // Wait for req to drop so a held request is not serviced twice.
        if (!bus.i_mem_req) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write at the ack edge only; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) ram[idx] <= new_word;
  end

  assign bus.or_mem_ack  = ack_q;
  assign bus.or_mem_err  = err_q;
  assign bus.or_mem_data = rdata_q;
  assign bus.or_busy     = (state_q != DMEM_IDLE);
endmodule
